// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine.
// Holds the memory-op codes, byte-lane geometry and small decode helpers
// used by the unit, its load aligner and anything forwarding from write-back.
package mem_access_unit_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned WORD_W    = BYTE_W * NUM_LANES;

  typedef enum logic [2:0] {
    MEMOP_NONE = 3'd0,
    MEMOP_LB   = 3'd1,
    MEMOP_LBU  = 3'd2,
    MEMOP_LW   = 3'd3,
    MEMOP_SB   = 3'd4,
    MEMOP_SW   = 3'd5
  } mem_op_e;

  // Codes 6 and 7 are reserved and fold onto NONE.
  function automatic mem_op_e decode_op(logic [2:0] code);
    case (code)
      3'd1:    return MEMOP_LB;
      3'd2:    return MEMOP_LBU;
      3'd3:    return MEMOP_LW;
      3'd4:    return MEMOP_SB;
      3'd5:    return MEMOP_SW;
      default: return MEMOP_NONE;
    endcase
  endfunction

  function automatic logic is_load(mem_op_e op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LW);
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op == MEMOP_SB) || (op == MEMOP_SW);
  endfunction

  // Word accesses are the only ones with an alignment constraint.
  function automatic logic is_word(mem_op_e op);
    return (op == MEMOP_LW) || (op == MEMOP_SW);
  endfunction

  function automatic logic [NUM_LANES-1:0] store_strb(mem_op_e op, logic [LANE_W-1:0] lane);
    case (op)
      MEMOP_SB: return 4'b0001 << lane;
      MEMOP_SW: return 4'hF;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding request/acknowledge data bus.
//   req/we/addr/wstrb/wdata : master -> slave, held stable while req is high
//   ack/rdata               : slave -> master, ack completes the request in the same cycle
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: selects the addressed byte lane of a read word
// and sign- or zero-extends it, or passes the word through for LW.
//   rdata     : raw bus word
//   lane      : byte lane (address bits [1:0]), little-endian
//   op        : load op; non-load ops produce zero
//   load_data : extended result
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [LANE_W-1:0] lane,
  input  mem_op_e           op,
  output logic [WORD_W-1:0] load_data
);

  logic [BYTE_W-1:0] byte_sel;

  always_comb begin
    byte_sel  = rdata[BYTE_W*lane +: BYTE_W];
    load_data = '0;
    case (op)
      MEMOP_LB:  load_data = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      MEMOP_LBU: load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      MEMOP_LW:  load_data = rdata;
      default:   load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine for LB, LBU, LW, SB and SW.
// Accepts an op from EX in IDLE, issues one bus request, and retires it with a
// one-cycle done pulse while holding the front of the pipeline via stall_req.
//   clk, rst      : clock, asynchronous active-high reset
//   ex_valid      : EX presents a memory op
//   mem_op        : op code (6/7 behave as NONE)
//   addr          : effective byte address
//   store_data    : store operand
//   stall_req     : hold IF/ID/EX
//   done          : access retired (pulse)
//   load_valid    : load_data valid (pulse)
//   load_data     : extended load result, held between retirements
//   misalign_err  : misaligned LW/SW (pulse, no bus access made)
//   bus           : request/acknowledge data bus, master side
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [2:0]         mem_op,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  store_data,
  output logic               stall_req,
  output logic               done,
  output logic               load_valid,
  output logic [DATA_W-1:0]  load_data,
  output logic               misalign_err,
  mem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e              state_q;
  mem_op_e             op_q;
  logic [LANE_W-1:0]   lane_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [NUM_LANES-1:0] bus_wstrb_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic                done_q;
  logic                load_valid_q;
  logic                misalign_q;
  logic [DATA_W-1:0]   load_data_q;

  mem_op_e             op_in;
  logic                active_in;
  logic                misalign_in;
  logic [DATA_W-1:0]   aligned_data;

  assign op_in       = decode_op(mem_op);
  assign active_in   = ex_valid && (op_in != MEMOP_NONE);
  assign misalign_in = is_word(op_in) && (addr[1:0] != 2'b00);

  // Dropped in StDone so the pipeline advances exactly once per access.
  assign stall_req = ((state_q == StIdle) && active_in) || (state_q == StReq);

  // Uses the lane/op captured at accept, so it stays valid while EX moves on.
  mem_access_unit_load_align u_load_align (
    .rdata     (bus.rdata),
    .lane      (lane_q),
    .op        (op_q),
    .load_data (aligned_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= MEMOP_NONE;
      lane_q       <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_wdata_q  <= '0;
      done_q       <= 1'b0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      load_data_q  <= '0;
    end else begin
      // Pulses default low; only the transition into StDone raises them.
      done_q       <= 1'b0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (active_in) begin
            if (misalign_in) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              misalign_q  <= 1'b1;
              load_data_q <= '0;
            end else begin
              state_q     <= StReq;
              op_q        <= op_in;
              lane_q      <= addr[1:0];
              bus_req_q   <= 1'b1;
              bus_we_q    <= is_store(op_in);
              bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wstrb_q <= store_strb(op_in, addr[1:0]);
              case (op_in)
                MEMOP_SB: bus_wdata_q <= {NUM_LANES{store_data[BYTE_W-1:0]}};
                MEMOP_SW: bus_wdata_q <= store_data;
                default:  bus_wdata_q <= '0;
              endcase
            end
          end
        end
        StReq: begin
          if (bus.ack) begin
            state_q   <= StDone;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (is_load(op_q)) begin
              load_valid_q <= 1'b1;
              load_data_q  <= aligned_data;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req      = bus_req_q;
  assign bus.we       = bus_we_q;
  assign bus.addr     = bus_addr_q;
  assign bus.wstrb    = bus_wstrb_q;
  assign bus.wdata    = bus_wdata_q;
  assign done         = done_q;
  assign load_valid   = load_valid_q;
  assign misalign_err = misalign_q;
  assign load_data    = load_data_q;

endmodule
